key_event_ctrl: RTL and testbench

//  Bus-mapped user-key input peripheral for the board-level MIPS system.

---
 rtl/key_event_ctrl_if.sv | 9 +
 rtl/key_event_ctrl.sv | 58 +++++
 tb/tb_key_event_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/key_event_ctrl_if.sv
// key_event_ctrl_if: word-addressed register bus between the system bridge and the key peripheral
interface key_event_ctrl_if;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output addr, we, wdata, input rdata);
  modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: synchronised, debounced keys with W1C press/release pending bits and a maskable irq
module key_event_ctrl #(
  parameter int N_KEYS = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk_in,
  input  logic              sys_rstn,
  input  logic [N_KEYS-1:0] key_n,
  key_event_ctrl_if.slave   bus,
  output logic              irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_KEYS-1:0] r_sync1, r_sync2, r_stable, r_pend_p, r_pend_r, r_irq_en;
  logic [N_KEYS-1:0] w_lvl, w_flip, w_wmask, w_rd;
  logic w_wr_p, w_wr_r, w_wr_en, w_unused;
  assign w_lvl   = ~r_sync2;
  assign w_wmask = bus.wdata[N_KEYS-1:0];
  assign w_wr_p  = bus.we && bus.addr == 4'h4;
  assign w_wr_r  = bus.we && bus.addr == 4'h8;
  assign w_wr_en = bus.we && bus.addr == 4'hC;
  assign w_unused = ^bus.wdata;
  always_ff @(posedge clk_in or negedge sys_rstn)
    if (!sys_rstn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [CNT_W-1:0] r_cnt;
    assign w_flip[k] = (w_lvl[k] != r_stable[k]) && (r_cnt == CNT_MAX);
    always_ff @(posedge clk_in or negedge sys_rstn)
      if (!sys_rstn) r_cnt <= '0;
      else r_cnt <= (w_lvl[k] == r_stable[k] || w_flip[k]) ? '0 : r_cnt + 1'b1;
  end
  // a new event on the same edge as a W1C clear wins over the clear
  always_ff @(posedge clk_in or negedge sys_rstn)
    if (!sys_rstn) begin
      r_stable <= '0;
      r_pend_p <= '0;
      r_pend_r <= '0;
      r_irq_en <= '0;
      irq      <= 1'b0;
    end else begin
      r_stable <= r_stable ^ w_flip;
      r_pend_p <= (r_pend_p & ~(w_wr_p ? w_wmask : '0)) | (w_flip & w_lvl);
      r_pend_r <= (r_pend_r & ~(w_wr_r ? w_wmask : '0)) | (w_flip & ~w_lvl);
      r_irq_en <= w_wr_en ? w_wmask : r_irq_en;
      irq      <= |((r_pend_p | r_pend_r) & r_irq_en);
    end
  assign w_rd = bus.addr == 4'h0 ? r_stable :
                bus.addr == 4'h4 ? r_pend_p :
                bus.addr == 4'h8 ? r_pend_r :
                bus.addr == 4'hC ? r_irq_en : '0;
  assign bus.rdata = 32'(w_rd);
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed scenarios plus randomized traffic against a window-based reference model
module tb_key_event_ctrl;
  localparam int N = 8;
  localparam int D = 4;
  logic clk_in = 1'b0;
  logic sys_rstn = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [31:0] key32_n = '1;
  logic [0:0] key1_n = 1'b1;
  logic irq, irq32, irq1;
  int n_chk = 0;
  int n_err = 0;
  key_event_ctrl_if bus();
  key_event_ctrl_if bus32();
  key_event_ctrl_if bus1();
  key_event_ctrl #(.N_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .key_n(key_n), .bus(bus), .irq(irq));
  key_event_ctrl #(.N_KEYS(32), .DEBOUNCE_CYCLES(1)) dut32 (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .key_n(key32_n), .bus(bus32), .irq(irq32));
  key_event_ctrl #(.N_KEYS(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .key_n(key1_n), .bus(bus1), .irq(irq1));
  always #5 clk_in = ~clk_in;
  // reference: raw keys delayed two samples; a key flips once its last D samples all differ from stable
  logic [N-1:0] m_d1, m_d2, m_stable, m_pp, m_pr, m_en, m_lvl, m_flip, m_wp, m_wr;
  logic [N-1:0] m_hist [D-1];
  logic m_irq;
  always_comb begin
    m_lvl  = ~m_d2;
    m_flip = m_lvl ^ m_stable;
    for (int i = 0; i < D - 1; i++) m_flip = m_flip & (m_hist[i] ^ m_stable);
    m_wp = (bus.we && bus.addr == 4'h4) ? bus.wdata[N-1:0] : '0;
    m_wr = (bus.we && bus.addr == 4'h8) ? bus.wdata[N-1:0] : '0;
  end
  always @(posedge clk_in or negedge sys_rstn)
    if (!sys_rstn) begin
      m_d1 <= '1;
      m_d2 <= '1;
      m_stable <= '0;
      m_pp <= '0;
      m_pr <= '0;
      m_en <= '0;
      m_irq <= 1'b0;
      for (int i = 0; i < D - 1; i++) m_hist[i] <= '0;
    end else begin
      m_d1 <= key_n;
      m_d2 <= m_d1;
      m_hist[0] <= m_lvl;
      for (int i = 1; i < D - 1; i++) m_hist[i] <= m_hist[i-1];
      m_stable <= m_stable ^ m_flip;
      m_pp <= (m_pp & ~m_wp) | (m_flip & m_lvl);
      m_pr <= (m_pr & ~m_wr) | (m_flip & ~m_lvl);
      if (bus.we && bus.addr == 4'hC) m_en <= bus.wdata[N-1:0];
      m_irq <= |((m_pp | m_pr) & m_en);
    end
  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return 32'(m_stable);
      4'h4: return 32'(m_pp);
      4'h8: return 32'(m_pr);
      4'hC: return 32'(m_en);
      default: return 32'h0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
    chk("rdata_model", bus.rdata, m_read(bus.addr));
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.we = 1'b1;
    bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask
  initial begin
    bus.addr = '0; bus.we = 1'b0; bus.wdata = '0;
    bus32.addr = '0; bus32.we = 1'b0; bus32.wdata = '0;
    bus1.addr = '0; bus1.we = 1'b0; bus1.wdata = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 16; a += 4) rd(4'(a), 32'h0, "rst_reg");
    sys_rstn = 1'b1;
    // reset in the middle of a debounce count
    key_n = 8'hFE;
    step(); step();
    sys_rstn = 1'b0;
    key_n = '1;
    #1 sys_rstn = 1'b1;
    repeat (8) step();
    rd(4'h0, 32'h0, "midrst_state");
    rd(4'h4, 32'h0, "midrst_pend_p");
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    // debounced press then release
    wr(4'hC, 32'h1);
    key_n = 8'hFE;
    repeat (5) step();
    key_n = '1;
    step();
    rd(4'h0, 32'h1, "press_state_e6");
    rd(4'h4, 32'h1, "press_pend_p");
    chk("press_irq_e6", {31'b0, irq}, 32'h0);
    step();
    chk("press_irq_e7", {31'b0, irq}, 32'h1);
    repeat (4) step();
    rd(4'h0, 32'h0, "release_state");
    rd(4'h8, 32'h1, "release_pend_r");
    wr(4'h4, 32'hFF);
    wr(4'h8, 32'hFF);
    // glitch of three samples
    key_n = 8'hF7;
    repeat (3) step();
    key_n = '1;
    repeat (8) step();
    rd(4'h0, 32'h0, "glitch_state");
    rd(4'h4, 32'h0, "glitch_pend_p");
    rd(4'h8, 32'h0, "glitch_pend_r");
    chk("glitch_irq", {31'b0, irq}, 32'h0);
    // W1C on the same edge as a new press event
    key_n = 8'hFE;
    repeat (5) step();
    wr(4'h4, 32'h1);
    rd(4'h4, 32'h1, "race_pend_p");
    wr(4'h4, 32'h1);
    rd(4'h4, 32'h0, "race_clear");
    step();
    chk("race_irq_drop", {31'b0, irq}, 32'h0);
    key_n = '1;
    repeat (8) step();
    wr(4'h8, 32'hFF);
    wr(4'hC, 32'h0);
    // masking and enable follow-through
    key_n = ~8'h42;
    repeat (8) step();
    rd(4'h4, 32'h42, "mask_pend_p");
    chk("mask_irq_off", {31'b0, irq}, 32'h0);
    wr(4'hC, 32'h40);
    step();
    chk("mask_irq_on", {31'b0, irq}, 32'h1);
    rd(4'hC, 32'h40, "mask_en");
    rd(4'h5, 32'h0, "unmapped_5");
    rd(4'hF, 32'h0, "unmapped_f");
    key_n = '1;
    repeat (8) step();
    wr(4'h4, 32'hFF);
    wr(4'h8, 32'hFF);
    wr(4'hC, 32'h0);
    // single-sample debounce at the width extremes
    key32_n = 32'h7FFF_FFFF;
    key1_n = 1'b0;
    bus1.addr = 4'hC; bus1.we = 1'b1; bus1.wdata = 32'hFFFF_FFFF;
    step(); step();
    chk("n32_state_e2", bus32.rdata, 32'h0);
    step();
    chk("n32_state_e3", bus32.rdata, 32'h8000_0000);
    bus1.we = 1'b0;
    bus32.addr = 4'h4;
    #1;
    chk("n32_pend_p", bus32.rdata, 32'h8000_0000);
    chk("n1_en_upper", bus1.rdata, 32'h1);
    bus1.addr = 4'h0;
    #1;
    chk("n1_state", bus1.rdata, 32'h1);
    step();
    chk("n1_irq", {31'b0, irq1}, 32'h1);
    chk("n32_irq_masked", {31'b0, irq32}, 32'h0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      key_n = key_n ^ N'($urandom & $urandom & $urandom);
      bus.we = ($urandom_range(0, 3) == 0);
      bus.addr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3) << 2);
      bus.wdata = $urandom;
      if (i == 1500) begin
        sys_rstn = 1'b0;
        #1 sys_rstn = 1'b1;
      end
      step();
    end
    bus.we = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
